// File: rtl/arr_pkg.sv
// Shared definitions for the array port arbiter.
//   ARR_DEPTH / ARR_ADDR_W / ARR_DATA_W : default array geometry
//   STARVE_LIMIT / STARVE_W             : owner grant budget while the other side waits
//   arb_state_e                         : arbiter ownership states
package arr_pkg;

    localparam int ARR_DEPTH    = 1000;
    localparam int ARR_ADDR_W   = 10;
    localparam int ARR_DATA_W   = 27;
    localparam int STARVE_LIMIT = 16;
    localparam int STARVE_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arr_rd_tracker.sv
// One-cycle read tag and read-data routing for the array port arbiter.
//   clk, rst_i           : clock, synchronous active-high reset
//   issue_i              : a read is granted this cycle
//   owner_i, oor_i       : granted requester (1 = kernel), address out of range
//   arr_rdata_i          : RAM read data (one cycle after the address)
//   rvalid0_o/rvalid1_o  : read result valid per requester
//   rdata0_o/rdata1_o    : read result per requester, holds when not valid
module arr_rd_tracker
    import arr_pkg::*;
#(
    parameter int DATA_W = ARR_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     issue_i,
    input  logic                     owner_i,
    input  logic                     oor_i,
    input  logic signed [DATA_W-1:0] arr_rdata_i,
    output logic                     rvalid0_o,
    output logic                     rvalid1_o,
    output logic signed [DATA_W-1:0] rdata0_o,
    output logic signed [DATA_W-1:0] rdata1_o
);

    logic                     valid_q;
    logic                     owner_q;
    logic                     oor_q;
    logic signed [DATA_W-1:0] rdata0_q;
    logic signed [DATA_W-1:0] rdata1_q;
    logic signed [DATA_W-1:0] rdata_sel;

    // Out-of-range reads still complete, but never expose RAM contents.
    assign rdata_sel = oor_q ? '0 : arr_rdata_i;

    // Gating with reset drops a tag issued in the cycle before reset.
    assign rvalid0_o = valid_q & ~owner_q & ~rst_i;
    assign rvalid1_o = valid_q &  owner_q & ~rst_i;

    assign rdata0_o = rst_i ? '0 : (rvalid0_o ? rdata_sel : rdata0_q);
    assign rdata1_o = rst_i ? '0 : (rvalid1_o ? rdata_sel : rdata1_q);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            owner_q  <= 1'b0;
            oor_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            valid_q <= issue_i;
            owner_q <= owner_i;
            oor_q   <= oor_i;
            if (rvalid0_o) rdata0_q <= rdata_sel;
            if (rvalid1_o) rdata1_q <= rdata_sel;
        end
    end

endmodule

// File: rtl/arr_port_arbiter.sv
// Two-requester arbiter in front of a single-port array RAM.
//   clk, r_enable                      : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN/lockN        : requester N access (0 = host, 1 = kernel)
//   gntN                               : combinational grant
//   rvalidN/rdataN                     : read result, one cycle after grant
//   errN                               : granted access had addrN >= DEPTH
//   arrWEnable_a/arrAddr_a/arrWData_a  : RAM port drive
//   arrRData_a                         : RAM read data
//
// state | meaning
// IDLE  | round-robin between requesters, rr_q picks the favoured one
// OWN0  | host holds the port while it keeps lock0 asserted
// OWN1  | kernel holds the port while it keeps lock1 asserted
module arr_port_arbiter
    import arr_pkg::*;
#(
    parameter int DEPTH  = ARR_DEPTH,
    parameter int ADDR_W = ARR_ADDR_W,
    parameter int DATA_W = ARR_DATA_W
) (
    input  logic                     clk,
    input  logic                     r_enable,
    input  logic                     req0,
    input  logic                     we0,
    input  logic        [ADDR_W-1:0] addr0,
    input  logic signed [DATA_W-1:0] wdata0,
    input  logic                     lock0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic        [ADDR_W-1:0] addr1,
    input  logic signed [DATA_W-1:0] wdata1,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic signed [DATA_W-1:0] rdata0,
    output logic signed [DATA_W-1:0] rdata1,
    output logic                     err0,
    output logic                     err1,
    output logic                     arrWEnable_a,
    output logic        [ADDR_W-1:0] arrAddr_a,
    output logic signed [DATA_W-1:0] arrWData_a,
    input  logic signed [DATA_W-1:0] arrRData_a
);

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    arb_state_e          state_q, state_d;
    logic                rr_q, rr_d;        // 1 = favour kernel in IDLE
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic in_range0, in_range1, sel_in_range, sel_we, any_gnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!r_enable) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0 = ~rr_q;
                        gnt1 =  rr_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0) begin
                    rr_d = 1'b1;
                    if (lock0) begin
                        state_d  = OWN0;
                        starve_d = req1 ? STARVE_W'(1) : '0;
                    end
                end else if (gnt1) begin
                    rr_d = 1'b0;
                    if (lock1) begin
                        state_d  = OWN1;
                        starve_d = req0 ? STARVE_W'(1) : '0;
                    end
                end
            end
            OWN0: begin
                if (!req0 || !lock0) begin
                    state_d  = IDLE;
                    rr_d     = 1'b1;
                    starve_d = '0;
                end else if (!req1) begin
                    starve_d = '0;
                end else if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                    state_d  = IDLE;
                    rr_d     = 1'b1;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            OWN1: begin
                if (!req1 || !lock1) begin
                    state_d  = IDLE;
                    rr_d     = 1'b0;
                    starve_d = '0;
                end else if (!req0) begin
                    starve_d = '0;
                end else if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                    state_d  = IDLE;
                    rr_d     = 1'b0;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

    assign in_range0    = ({1'b0, addr0} < DEPTH_X);
    assign in_range1    = ({1'b0, addr1} < DEPTH_X);
    assign any_gnt      = gnt0 | gnt1;
    assign sel_we       = gnt1 ? we1 : we0;
    assign sel_in_range = gnt1 ? in_range1 : in_range0;

    assign arrWEnable_a = any_gnt & sel_we & sel_in_range;
    assign arrAddr_a    = gnt1 ? addr1 : addr0;
    assign arrWData_a   = gnt1 ? wdata1 : wdata0;

    assign err0 = gnt0 & ~in_range0;
    assign err1 = gnt1 & ~in_range1;

    arr_rd_tracker #(
        .DATA_W (DATA_W)
    ) u_rd_tracker (
        .clk         (clk),
        .rst_i       (r_enable),
        .issue_i     (any_gnt & ~sel_we),
        .owner_i     (gnt1),
        .oor_i       (~sel_in_range),
        .arr_rdata_i (arrRData_a),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1)
    );

endmodule
